// File: rtl/add_sched_24_pkg.sv
// add_sched_pkg: shared lane width, requester tags and scheduler state encoding
// Contents:
//   LW         adder lane width (24)
//   REQ0/REQ1  tag values identifying requester 0 / requester 1
//   state_t    scheduler states IDLE, LO, HI, DONE
package add_sched_pkg;
    localparam int   LW   = 24;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
endpackage

// File: rtl/add_sched_24_cla.sv
// ADD_CLA_24: 24-bit carry-lookahead adder lane
// Ports:
//   i_a, i_b  in  LW  addends
//   i_c       in  1   carry-in
//   o_s       out LW  sum
//   o_c       out 1   carry-out
module ADD_CLA_24
    import add_sched_pkg::*;
(
    input  logic [LW-1:0] i_a,
    input  logic [LW-1:0] i_b,
    input  logic          i_c,
    output logic [LW-1:0] o_s,
    output logic          o_c
);
    logic [LW-1:0] w_g;
    logic [LW-1:0] w_p;
    logic [LW-1:0] w_c;
    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;
    // Each carry is expanded from generate/propagate terms alone, so every
    // bit is a flat lookahead expression rather than a chain through w_c.
    always_comb begin
        logic t;
        w_c = '0;
        for (int i = 0; i < LW; i++) begin
            t = i_c;
            for (int j = 0; j <= i; j++) t = w_g[j] | (w_p[j] & t);
            w_c[i] = t;
        end
    end
    assign o_s = w_p ^ {w_c[LW-2:0], i_c};
    assign o_c = w_c[LW-1];
endmodule

// File: rtl/add_sched_24.sv
// add_sched_24: two-requester scheduler sharing one 24-bit adder lane for 24/48-bit adds
// Ports:
//   iClk, iRstn              clock, asynchronous active-low reset
//   iVk, iAk, iBk, iCk, iWk  requester k valid, operands, carry-in, wide flag (k = 0,1)
//   oR0, oR1                 requester ready (granted requester while IDLE)
//   oV, oS, oC, oTag         result valid, sum, carry-out, owning requester
//   iR                       result consumer ready
//   oBusy                    high whenever the scheduler is not IDLE
module add_sched_24
    import add_sched_pkg::*;
#(
    parameter int LW = 24
) (
    input  logic            iClk,
    input  logic            iRstn,
    input  logic            iV0,
    input  logic [2*LW-1:0] iA0,
    input  logic [2*LW-1:0] iB0,
    input  logic            iC0,
    input  logic            iW0,
    input  logic            iV1,
    input  logic [2*LW-1:0] iA1,
    input  logic [2*LW-1:0] iB1,
    input  logic            iC1,
    input  logic            iW1,
    output logic            oR0,
    output logic            oR1,
    output logic            oV,
    output logic [2*LW-1:0] oS,
    output logic            oC,
    output logic            oTag,
    input  logic            iR,
    output logic            oBusy
);
    state_t          r_state;
    state_t          w_next;
    logic            r_ptr;
    logic [2*LW-1:0] r_a;
    logic [2*LW-1:0] r_b;
    logic            r_cin;
    logic            r_w;
    logic            r_tag;
    logic [2*LW-1:0] r_s;
    logic            r_c;
    logic            r_cy;
    logic            w_any;
    logic            w_g;
    logic            w_acc;
    logic [LW-1:0]   w_opa;
    logic [LW-1:0]   w_opb;
    logic            w_ci;
    logic [LW-1:0]   w_sum;
    logic            w_co;

    assign w_any = iV0 | iV1;
    // Contention goes to the round-robin pointer, otherwise to whoever is valid.
    assign w_g   = (iV0 & iV1) ? r_ptr : (iV1 ? REQ1 : REQ0);
    assign w_acc = (r_state == IDLE) & w_any;

    // Lane selection depends only on the state register, never on live inputs.
    assign w_opa = (r_state == HI) ? r_a[2*LW-1:LW] : r_a[LW-1:0];
    assign w_opb = (r_state == HI) ? r_b[2*LW-1:LW] : r_b[LW-1:0];
    assign w_ci  = (r_state == HI) ? r_cy : r_cin;

    ADD_CLA_24 u_cla (
        .i_a(w_opa),
        .i_b(w_opb),
        .i_c(w_ci),
        .o_s(w_sum),
        .o_c(w_co)
    );

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        oR0    = 1'b0;
        oR1    = 1'b0;
        unique case (r_state)
            IDLE: begin
                oR0    = w_any & ~w_g;
                oR1    = w_any & w_g;
                w_next = w_any ? LO : IDLE;
            end
            LO:      w_next = r_w ? HI : DONE;
            HI:      w_next = DONE;
            DONE:    w_next = iR ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_ptr <= REQ0;
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
            r_w   <= 1'b0;
            r_tag <= REQ0;
            r_s   <= '0;
            r_c   <= 1'b0;
            r_cy  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_a   <= w_g ? iA1 : iA0;
                r_b   <= w_g ? iB1 : iB0;
                r_cin <= w_g ? iC1 : iC0;
                r_w   <= w_g ? iW1 : iW0;
                r_tag <= w_g;
                r_ptr <= ~w_g;
            end
            if (r_state == LO) begin
                r_s[LW-1:0] <= w_sum;
                r_cy        <= w_co;
                if (!r_w) begin
                    r_s[2*LW-1:LW] <= '0;
                    r_c            <= w_co;
                end
            end
            if (r_state == HI) begin
                r_s[2*LW-1:LW] <= w_sum;
                r_c            <= w_co;
            end
        end
    end

    assign oV    = (r_state == DONE);
    assign oS    = r_s;
    assign oC    = r_c;
    assign oTag  = r_tag;
    assign oBusy = (r_state != IDLE);
endmodule

// File: tb/tb_add_sched_24.sv
// tb_add_sched_24: scoreboard bench for add_sched_24 with directed and random traffic
module tb_add_sched_24;
    typedef struct {
        logic [47:0] s;
        logic        c;
        logic        tag;
    } exp_t;

    logic        iClk = 1'b0;
    logic        iRstn;
    logic        iV0, iV1, iC0, iC1, iW0, iW1, iR;
    logic [47:0] iA0, iB0, iA1, iB1;
    logic        oR0, oR1, oV, oC, oTag, oBusy;
    logic [47:0] oS;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q[$];
    logic m_busy = 1'b0;
    logic m_ptr  = 1'b0;
    int   m_t    = 0;

    add_sched_24 dut (
        .iClk(iClk), .iRstn(iRstn),
        .iV0(iV0), .iA0(iA0), .iB0(iB0), .iC0(iC0), .iW0(iW0),
        .iV1(iV1), .iA1(iA1), .iB1(iB1), .iC1(iC1), .iW1(iW1),
        .oR0(oR0), .oR1(oR1), .oV(oV), .oS(oS), .oC(oC), .oTag(oTag),
        .iR(iR), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc++;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result from plain integer arithmetic on the operand widths.
    function automatic exp_t model(input logic [47:0] a, input logic [47:0] b,
                                   input logic c, input logic w, input logic tag);
        exp_t        e;
        logic [48:0] t;
        logic [24:0] n;
        t = {1'b0, a} + {1'b0, b} + 49'(c);
        n = {1'b0, a[23:0]} + {1'b0, b[23:0]} + 25'(c);
        e.s   = w ? t[47:0] : {24'h0, n[23:0]};
        e.c   = w ? t[48] : n[24];
        e.tag = tag;
        return e;
    endfunction

    function automatic logic [47:0] rnd48();
        return ($urandom_range(0, 3) == 0) ? 48'hFFFFFFFFFFFF : {16'($urandom), 32'($urandom)};
    endfunction

    // Monitor: tracks one outstanding operation, its due cycle and the pointer.
    always @(negedge iClk) begin
        logic g;
        logic ev;
        if (!iRstn) begin
            q.delete();
            m_busy = 1'b0;
            m_ptr  = 1'b0;
            chk("rst_oV", oV, 0);
            chk("rst_oS", oS, 0);
            chk("rst_oC", oC, 0);
            chk("rst_oTag", oTag, 0);
            chk("rst_busy", oBusy, 0);
        end else begin
            g  = (iV0 && iV1) ? m_ptr : iV1;
            ev = m_busy && (cyc >= m_t);
            chk("busy", oBusy, m_busy);
            chk("oV", oV, ev);
            chk("oR0", oR0, !m_busy && (iV0 || iV1) && !g);
            chk("oR1", oR1, !m_busy && (iV0 || iV1) && g);
            if (ev && q.size() > 0) begin
                chk("oS", oS, q[0].s);
                chk("oC", oC, q[0].c);
                chk("oTag", oTag, q[0].tag);
                if (iR) begin
                    void'(q.pop_front());
                    m_busy = 1'b0;
                end
            end else if (!m_busy && (iV0 || iV1)) begin
                q.push_back(model(g ? iA1 : iA0, g ? iB1 : iB0, g ? iC1 : iC0, g ? iW1 : iW0, g));
                m_busy = 1'b1;
                m_t    = cyc + ((g ? iW1 : iW0) ? 3 : 2);
                m_ptr  = !g;
            end
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iRstn = 1'b0; iR = 1'b1;
        iV0 = 1'b0; iA0 = '0; iB0 = '0; iC0 = 1'b0; iW0 = 1'b0;
        iV1 = 1'b0; iA1 = '0; iB1 = '0; iC1 = 1'b0; iW1 = 1'b0;
        repeat (2) tick();
        // narrow lane wrap, issued right after reset release
        iRstn = 1'b1;
        iV0 = 1'b1; iA0 = 48'h000000FFFFFF; iB0 = 48'h1; iC0 = 1'b0; iW0 = 1'b0;
        tick(); iV0 = 1'b0; repeat (3) tick();
        // wide carry across the lane boundary
        iV1 = 1'b1; iA1 = 48'h000000FFFFFF; iB1 = 48'h1; iC1 = 1'b0; iW1 = 1'b1;
        tick(); iV1 = 1'b0; repeat (4) tick();
        // wide overflow into carry-out
        iV0 = 1'b1; iA0 = 48'hFFFFFFFFFFFF; iB0 = 48'h0; iC0 = 1'b1; iW0 = 1'b1;
        tick(); iV0 = 1'b0; repeat (4) tick();
        // contention from a fresh pointer
        iRstn = 1'b0; tick(); iRstn = 1'b1;
        iV0 = 1'b1; iV1 = 1'b1;
        repeat (20) begin
            iA0 = rnd48(); iB0 = rnd48(); iC0 = 1'($urandom); iW0 = 1'($urandom);
            iA1 = rnd48(); iB1 = rnd48(); iC1 = 1'($urandom); iW1 = 1'($urandom);
            tick();
        end
        // consumer backpressure while requester 0 keeps asking
        iV1 = 1'b0; iR = 1'b0;
        repeat (8) tick();
        iR = 1'b1;
        repeat (6) tick();
        iV0 = 1'b0;
        repeat (4) tick();
        // reset while the high lane is in progress
        iV1 = 1'b1; iA1 = 48'h123456FFFFFF; iB1 = 48'h000001000001; iC1 = 1'b1; iW1 = 1'b1;
        tick(); iV1 = 1'b0;
        tick();
        chk("hi_busy", oBusy, 1);
        iRstn = 1'b0;
        #1;
        chk("hi_rst_oV", oV, 0);
        chk("hi_rst_oS", oS, 0);
        chk("hi_rst_busy", oBusy, 0);
        tick();
        iRstn = 1'b1;
        iV0 = 1'b1; iA0 = 48'h800000800000; iB0 = 48'h800000800000; iC0 = 1'b1; iW0 = 1'b1;
        tick(); iV0 = 1'b0; repeat (4) tick();
        // random traffic with occasional resets
        repeat (600) begin
            iRstn = ($urandom_range(0, 99) != 0);
            iV0 = 1'($urandom); iA0 = rnd48(); iB0 = rnd48(); iC0 = 1'($urandom); iW0 = 1'($urandom);
            iV1 = 1'($urandom); iA1 = rnd48(); iB1 = rnd48(); iC1 = 1'($urandom); iW1 = 1'($urandom);
            iR = ($urandom_range(0, 3) != 0);
            tick();
        end
        iRstn = 1'b1; iV0 = 1'b0; iV1 = 1'b0; iR = 1'b1;
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
